// File: rtl/dbg_uart_tx.sv
// Debug UART byte transmitter: start / LSB-first data / optional parity / stop bits.
// o_rdy looks one cycle ahead so consecutive frames leave no idle gap on the line.
module dbg_uart_tx #(
    parameter int CLKFREQ  = 75_000_000,
    parameter int BAUDRATE = 115_200,
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_rdy,
    output logic       o_busy,
    output logic       o_tx
);

    localparam int CPB = (CLKFREQ + BAUDRATE / 2) / BAUDRATE;
    localparam int CW  = (CPB < 2) ? 1 : $clog2(CPB);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [2:0]    DBIT_LAST = 3'(DATABITS - 1);
    localparam logic [2:0]    SBIT_LAST = 3'(STOPBITS - 1);
    localparam logic [7:0]    DMASK     = 8'((16'd1 << DATABITS) - 16'd1);

    if (CPB < 2 || DATABITS < 5 || DATABITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOPBITS < 1 || STOPBITS > 2) begin : g_cfg_err
        $error("dbg_uart_tx: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Odd mode inverts the XOR so the total count of ones becomes odd.
    function automatic logic calc_parity(input logic [7:0] d);
        logic p;
        if (PARITY == 1) begin
            p = ~^d;
        end else begin
            p = ^d;
        end
        return p;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q,   par_d;
    logic          tx_q,    tx_d;
    logic          busy_q,  busy_d;

    logic          cnt_last_s;
    logic          rdy_s;
    logic          accept_s;

    assign cnt_last_s = (cnt_q == CNT_LAST);
    assign rdy_s      = (state_q == ST_IDLE) ||
                        ((state_q == ST_STOP) && cnt_last_s && (bit_q == SBIT_LAST));
    assign accept_s   = i_start & rdy_s;

    assign o_rdy  = rdy_s;
    assign o_busy = busy_q;
    assign o_tx   = tx_q;

    // Next-state logic: an accept overrides everything, otherwise step the frame per bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        if (accept_s) begin
            state_d = ST_START;
            cnt_d   = '0;
            bit_d   = 3'd0;
            shreg_d = i_data & DMASK;
            par_d   = calc_parity(i_data & DMASK);
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (state_q == ST_IDLE) begin
            cnt_d  = '0;
            bit_d  = 3'd0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
        end else if (!cnt_last_s) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
                ST_DATA: begin
                    if (bit_q != DBIT_LAST) begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end else if (PARITY != 0) begin
                        state_d = ST_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = ST_STOP;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                end
                ST_STOP: begin
                    tx_d = 1'b1;
                    if (bit_q != SBIT_LAST) begin
                        bit_d = bit_q + 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                        bit_d   = 3'd0;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset drives the line high immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Scoreboard bench for dbg_uart_tx: three configurations, expected line levels queued per accept
// and compared cycle by cycle by a negedge monitor.
module tb_dbg_uart_tx;

    localparam int N = 3;
    // Per-instance frame shape: cycles per bit, data bits, parity mode, stop bits.
    localparam int CPB_C [N] = '{4, 4, 5};
    localparam int DB_C  [N] = '{8, 8, 6};
    localparam int PAR_C [N] = '{0, 2, 1};
    localparam int SB_C  [N] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [N];
    logic [7:0] data  [N];
    logic       tx    [N];
    logic       rdy   [N];
    logic       busy  [N];

    bit exp_q [N][$];
    int acc_cnt [N];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbg_uart_tx #(.CLKFREQ(400), .BAUDRATE(100), .DATABITS(8), .PARITY(0), .STOPBITS(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_data(data[0]),
        .o_rdy(rdy[0]), .o_busy(busy[0]), .o_tx(tx[0]));
    dbg_uart_tx #(.CLKFREQ(400), .BAUDRATE(100), .DATABITS(8), .PARITY(2), .STOPBITS(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_data(data[1]),
        .o_rdy(rdy[1]), .o_busy(busy[1]), .o_tx(tx[1]));
    dbg_uart_tx #(.CLKFREQ(450), .BAUDRATE(100), .DATABITS(6), .PARITY(1), .STOPBITS(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_data(data[2]),
        .o_rdy(rdy[2]), .o_busy(busy[2]), .o_tx(tx[2]));

    task automatic check(input string name, input int idx, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%b want=%b", name, idx, $time, got, want);
        end
    endtask

    // Reference model: a byte is taken whenever no expected levels remain; the frame is queued as levels.
    always @(posedge clk) begin : model
        int ones, nbits, lvl;
        logic [7:0] d;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                exp_q[i].delete();
            end else if (start[i] && exp_q[i].size() == 0) begin
                d     = data[i] & 8'((1 << DB_C[i]) - 1);
                ones  = $countones(d);
                nbits = 1 + DB_C[i] + ((PAR_C[i] != 0) ? 1 : 0) + SB_C[i];
                for (int b = 0; b < nbits; b++) begin
                    if (b == 0)                                 lvl = 0;
                    else if (b <= DB_C[i])                      lvl = int'(d[b-1]);
                    else if (PAR_C[i] == 2 && b == DB_C[i] + 1) lvl = ones % 2;
                    else if (PAR_C[i] == 1 && b == DB_C[i] + 1) lvl = 1 - (ones % 2);
                    else                                        lvl = 1;
                    for (int c = 0; c < CPB_C[i]; c++) exp_q[i].push_back(bit'(lvl));
                end
                acc_cnt[i]++;
            end
        end
    end

    // Monitor: every cycle each instance either shows the next queued level or an idle line.
    always @(negedge clk) begin : monitor
        bit lvl;
        for (int i = 0; i < N; i++) begin
            if (!rst_n || exp_q[i].size() == 0) begin
                check("idle_tx", i, tx[i], 1'b1);
                check("idle_rdy", i, rdy[i], 1'b1);
                check("idle_busy", i, busy[i], 1'b0);
            end else begin
                lvl = exp_q[i].pop_front();
                check("tx", i, tx[i], lvl);
                check("busy", i, busy[i], 1'b1);
                check("rdy", i, rdy[i], exp_q[i].size() == 0);
            end
        end
    end

    // Offer a byte and wait (bounded) for the model to take it; keep=1 leaves i_start high.
    task automatic send(input int idx, input logic [7:0] d, input bit keep);
        int c;
        bit done;
        c = acc_cnt[idx];
        done = 1'b0;
        @(negedge clk);
        start[idx] = 1'b1;
        data[idx]  = d;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (acc_cnt[idx] != c) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout dut%0d got=no_accept want=accept", idx);
        end
        if (!keep) start[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 2000 && !idle; k++) begin
            @(negedge clk);
            idle = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL idle_timeout got=busy want=idle");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b1;
            data[i]  = 8'h5A;
        end
        // Reset held with i_start asserted; the first edge after release must accept.
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) start[i] = 1'b0;
        wait_idle();

        send(0, 8'hA5, 1'b0);
        wait_idle();

        // Back-to-back with i_start held high.
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b0);
        wait_idle();

        // Requests while busy must be dropped.
        send(0, 8'h3C, 1'b0);
        repeat (9) @(negedge clk);
        start[0] = 1'b1; data[0] = 8'hFF;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        start[0] = 1'b1; data[0] = 8'hFF;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle();

        send(1, 8'h07, 1'b0);
        send(2, 8'h07, 1'b0);
        wait_idle();

        // Asynchronous reset in the middle of data bit 3 (a 0 bit of 0xA5).
        send(0, 8'hA5, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        check("pre_reset_tx", 0, tx[0], 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_tx", 0, tx[0], 1'b1);
        check("async_rdy", 0, rdy[0], 1'b1);
        check("async_busy", 0, busy[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h55, 1'b0);
        wait_idle();

        // Randomized traffic on all instances.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                data[i]  = 8'($urandom);
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) start[i] = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
